// File: rtl/display_scan_ctrl.sv
// Scan sequencer for a 3-digit multiplexed 7-segment display: per-slot blanking,
// frame-boundary double buffering of the BCD value, optional leading-zero suppression.
module display_scan_ctrl #(
  parameter int unsigned DIV   = 50000,
  parameter int unsigned BLANK = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [11:0] bcd_in,
  input  logic        lz_en,
  output logic [2:0]  dsel,
  output logic [3:0]  digit,
  output logic        seg_blank,
  output logic        frame_tick,
  output logic        pending
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CntLast  = CW'(DIV - 1);
  localparam logic [CW-1:0] CntBlank = CW'(BLANK);

  typedef enum logic [1:0] {StIdle, StUnits, StTens, StHundreds} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   shadow_q, shadow_d, active_q, active_d;
  logic          pending_q, pending_d;
  logic          boundary;
  logic          supp;
  logic [2:0]    dsel_d;
  logic [3:0]    digit_d;
  logic          seg_blank_d, frame_tick_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    boundary = 1'b0;
    if (!en) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d  = StUnits;
          cnt_d    = '0;
          boundary = 1'b1;
        end
        StUnits: if (cnt_q == CntLast) begin
          state_d = StTens;
          cnt_d   = '0;
        end
        StTens: if (cnt_q == CntLast) begin
          state_d = StHundreds;
          cnt_d   = '0;
        end
        StHundreds: if (cnt_q == CntLast) begin
          state_d  = StUnits;
          cnt_d    = '0;
          boundary = 1'b1;
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // A load on the boundary edge bypasses the shadow so the newest value wins.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (boundary) begin
      if (load) begin
        active_d = bcd_in;
        shadow_d = bcd_in;
      end else if (pending_q) begin
        active_d = shadow_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      shadow_d  = bcd_in;
      pending_d = 1'b1;
    end
  end

  // Outputs are computed from the next state so the registered copy matches state_q/cnt_q.
  always_comb begin
    dsel_d  = 3'b111;
    digit_d = 4'd0;
    supp    = 1'b0;
    unique case (state_d)
      StUnits: begin
        dsel_d  = 3'b110;
        digit_d = active_d[3:0];
      end
      StTens: begin
        dsel_d  = 3'b101;
        digit_d = active_d[7:4];
        supp    = lz_en && (active_d[11:4] == 8'd0);
      end
      StHundreds: begin
        dsel_d  = 3'b011;
        digit_d = active_d[11:8];
        supp    = lz_en && (active_d[11:8] == 4'd0);
      end
      default: ;
    endcase
    if ((cnt_d < CntBlank) || supp) dsel_d = 3'b111;
    seg_blank_d  = (dsel_d == 3'b111) || (digit_d > 4'd9);
    frame_tick_d = (state_d == StHundreds) && (cnt_d == CntLast);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsel       <= 3'b111;
      digit      <= 4'd0;
      seg_blank  <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      dsel       <= dsel_d;
      digit      <= digit_d;
      seg_blank  <= seg_blank_d;
      frame_tick <= frame_tick_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: directed steps plus random traffic, checked against a
// frame-position model (position within a 3*DIV frame, slot = pos/DIV).
module tb_display_scan_ctrl;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 3 * DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [11:0] bcd_in;
  logic        lz_en;
  logic [2:0]  dsel;
  logic [3:0]  digit;
  logic        seg_blank;
  logic        frame_tick;
  logic        pending;

  display_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .bcd_in     (bcd_in),
    .lz_en      (lz_en),
    .dsel       (dsel),
    .digit      (digit),
    .seg_blank  (seg_blank),
    .frame_tick (frame_tick),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  int cmp = 0;
  int mis = 0;
  int cyc = 0;

  // Reference model state
  bit          m_run;
  int          pos;
  logic [11:0] m_shadow, m_active;
  bit          m_pend;
  logic [2:0]  e_dsel;
  logic [3:0]  e_digit;
  bit          e_blank, e_tick;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp)
    else begin
      mis++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_run = 0; pos = 0; m_shadow = '0; m_active = '0; m_pend = 0;
    e_dsel = 3'b111; e_digit = 4'd0; e_blank = 1; e_tick = 0;
  endtask

  task automatic model_edge();
    bit boundary;
    int slot, off;
    logic [3:0] nib;
    bit supp;
    if (!en) begin
      m_run = 0;
      pos   = 0;
      if (load) begin m_shadow = bcd_in; m_pend = 1; end
    end else begin
      boundary = !m_run || (pos == FRAME - 1);
      pos      = boundary ? 0 : pos + 1;
      m_run    = 1;
      if (boundary) begin
        if (load) begin m_active = bcd_in; m_shadow = bcd_in; end
        else if (m_pend) m_active = m_shadow;
        m_pend = 0;
      end else if (load) begin
        m_shadow = bcd_in; m_pend = 1;
      end
    end
    if (!m_run) begin
      e_dsel = 3'b111; e_digit = 4'd0; e_blank = 1; e_tick = 0;
    end else begin
      slot = pos / DIV;
      off  = pos % DIV;
      nib  = 4'((m_active >> (4 * slot)) & 12'hf);
      supp = lz_en && ((slot == 2 && m_active[11:8] == 0) ||
                       (slot == 1 && m_active[11:4] == 0));
      if (off < BLANK || supp) e_dsel = 3'b111;
      else e_dsel = (slot == 0) ? 3'b110 : (slot == 1) ? 3'b101 : 3'b011;
      e_digit = nib;
      e_blank = (e_dsel == 3'b111) || (nib > 4'd9);
      e_tick  = (pos == FRAME - 1);
    end
  endtask

  task automatic check_all();
    chk("dsel", 32'(dsel), 32'(e_dsel));
    if (e_dsel != 3'b111 || !m_run) chk("digit", 32'(digit), 32'(e_digit));
    chk("seg_blank", 32'(seg_blank), 32'(e_blank));
    chk("frame_tick", 32'(frame_tick), 32'(e_tick));
    chk("pending", 32'(pending), 32'(m_pend));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until(input int p);
    int n = 0;
    while (!(m_run && pos == p) && n < 100) begin
      step();
      n++;
    end
    chk("reach_pos", 32'(m_run && pos == p), 32'd1);
  endtask

  task automatic do_load(input logic [11:0] v);
    load = 1'b1; bcd_in = v;
    step();
    load = 1'b0;
  endtask

  function automatic logic [3:0] rnd_nib();
    int r = $urandom_range(0, 15);
    if (r < 5) return 4'd0;
    if (r < 14) return 4'($urandom_range(1, 9));
    return 4'($urandom_range(10, 15));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int last_tick;
    rst_n = 1'b0; en = 1'b0; load = 1'b0; bcd_in = '0; lz_en = 1'b0;
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;

    // Idle with scan disabled
    steps(20);

    // Plain scan of 0x123 with frame period measurement
    do_load(12'h123);
    en = 1'b1;
    last_tick = -1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      if (frame_tick) begin
        if (last_tick >= 0) chk("frame_period", 32'(cyc - last_tick), 32'(FRAME));
        last_tick = cyc;
      end
    end

    // Leading-zero suppression
    lz_en = 1'b1;
    do_load(12'h007);
    steps(2 * FRAME);
    do_load(12'h070);
    steps(2 * FRAME);
    lz_en = 1'b0;

    // Mid-frame load, then load coincident with the boundary edge
    run_until(DIV + 3);
    do_load(12'h456);
    run_until(FRAME - 1);
    steps(10);
    run_until(FRAME - 1);
    do_load(12'h789);
    steps(FRAME);

    // Drop enable mid-hundreds, then resume
    run_until(2 * DIV + 4);
    en = 1'b0;
    steps(4);
    en = 1'b1;
    steps(FRAME + 4);

    // Invalid BCD in the tens slot, then asynchronous reset mid-slot
    do_load(12'h0A5);
    run_until(FRAME - 1);
    run_until(DIV + BLANK + 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    rst_n = 1'b1;
    en = 1'b0;
    steps(3);
    en = 1'b1;

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      en     = ($urandom_range(0, 40) != 0);
      load   = ($urandom_range(0, 7) == 0);
      bcd_in = {rnd_nib(), rnd_nib(), rnd_nib()};
      if ($urandom_range(0, 15) == 0) lz_en = ~lz_en;
      step();
    end
    load = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

endmodule
